// File: rtl/scan_sequencer.sv
// -----------------------------------------------------------------------------
// scan_sequencer
//   Top-level controller for the board-evaluation scanners. On an accepted
//   start it walks the latched enable mask from index 0 upward, launches each
//   enabled scanner with a one-cycle pulse and grants that scanner the shared
//   board-read / weight-write port while it runs. A per-scanner watchdog
//   abandons a scanner that does not report done within TIMEOUT cycles.
//   allDone pulses once when the whole pass is over.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   start, scanMask     pass request (sampled in IDLE) and per-scanner enable
//   enaScanOut          one-cycle launch pulse per scanner
//   doneScanIn          per-scanner done flags
//   enaReadIn/WriteIn   per-scanner read / write requests
//   xIn, yIn, weightIn  packed per-scanner coordinates and write data
//   memX/memY/memRead/memWrite/memWeight   shared port (granted scanner only)
//   activeIdx           index of the current or last scanner
//   busy, allDone       pass in progress / end-of-pass pulse
//   timeoutErr          sticky per-pass watchdog error
// -----------------------------------------------------------------------------
module scan_sequencer #(
   parameter int N_SCAN   = 4,
   parameter int ADDR_W   = 5,
   parameter int WEIGHT_W = 4,
   parameter int TIMEOUT  = 4095,
   parameter int TMR_W    = 12,
   localparam int IDX_W   = (N_SCAN > 1) ? $clog2(N_SCAN) : 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic [N_SCAN-1:0]            scanMask,
   output logic [N_SCAN-1:0]            enaScanOut,
   input  logic [N_SCAN-1:0]            doneScanIn,
   input  logic [N_SCAN-1:0]            enaReadIn,
   input  logic [N_SCAN-1:0]            enaWriteIn,
   input  logic [N_SCAN*ADDR_W-1:0]     xIn,
   input  logic [N_SCAN*ADDR_W-1:0]     yIn,
   input  logic [N_SCAN*WEIGHT_W-1:0]   weightIn,
   output logic [ADDR_W-1:0]            memX,
   output logic [ADDR_W-1:0]            memY,
   output logic                         memRead,
   output logic                         memWrite,
   output logic [WEIGHT_W-1:0]          memWeight,
   output logic [IDX_W-1:0]             activeIdx,
   output logic                         busy,
   output logic                         allDone,
   output logic                         timeoutErr
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SELECT = 3'd1,
      ST_LAUNCH = 3'd2,
      ST_WAIT   = 3'd3,
      ST_FINISH = 3'd4
   } state_e;

   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_SCAN - 1);
   localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT);

   state_e              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [TMR_W-1:0]    timer_q, timer_d;
   logic [N_SCAN-1:0]   mask_q, mask_d;
   logic                terr_q, terr_d;
   logic [N_SCAN-1:0]   ena_q, ena_d;
   logic                busy_q, busy_d;
   logic                all_done_q, all_done_d;

   // State register and registered status outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         idx_q      <= '0;
         timer_q    <= '0;
         mask_q     <= '0;
         terr_q     <= 1'b0;
         ena_q      <= '0;
         busy_q     <= 1'b0;
         all_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         timer_q    <= timer_d;
         mask_q     <= mask_d;
         terr_q     <= terr_d;
         ena_q      <= ena_d;
         busy_q     <= busy_d;
         all_done_q <= all_done_d;
      end
   end

   // Next-state, scanner index, watchdog and sticky-error logic
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      timer_d = timer_q;
      mask_d  = mask_q;
      terr_d  = terr_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               mask_d  = scanMask;
               terr_d  = 1'b0;
               idx_d   = '0;
               state_d = ST_SELECT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SELECT: begin
            // A disabled scanner is skipped at the cost of one cycle.
            if (mask_q[idx_q]) begin
               state_d = ST_LAUNCH;
            end else if (idx_q == LAST_IDX) begin
               state_d = ST_FINISH;
            end else begin
               idx_d   = idx_q + IDX_W'(1);
               state_d = ST_SELECT;
            end
         end
         ST_LAUNCH: begin
            timer_d = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            timer_d = timer_q + TMR_W'(1);
            // On the first WAIT cycle the done flag may still be the one the
            // scanner left high at the end of the previous pass, so it is not
            // trusted until one cycle after the launch.
            if (((timer_q != '0) && doneScanIn[idx_q]) || (timer_q == TMR_LIMIT)) begin
               if ((timer_q == '0) || !doneScanIn[idx_q]) begin
                  terr_d = 1'b1;
               end else begin
                  terr_d = terr_q;
               end
               if (idx_q == LAST_IDX) begin
                  state_d = ST_FINISH;
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  state_d = ST_SELECT;
               end
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_FINISH: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output decode: registered launch/status flags and the zero-latency grant mux
   always_comb begin
      ena_d      = '0;
      busy_d     = (state_d != ST_IDLE);
      all_done_d = (state_d == ST_FINISH);
      memX       = '0;
      memY       = '0;
      memWeight  = '0;
      memRead    = 1'b0;
      memWrite   = 1'b0;
      for (int i = 0; i < N_SCAN; i++) begin
         ena_d[i] = (state_d == ST_LAUNCH) && (idx_d == IDX_W'(i));
      end
      // AND-OR mux: only the scanner granted in WAIT reaches the shared port.
      for (int i = 0; i < N_SCAN; i++) begin
         memX      = memX      | ({ADDR_W{(state_q == ST_WAIT) && (idx_q == IDX_W'(i))}}
                                  & xIn[i*ADDR_W +: ADDR_W]);
         memY      = memY      | ({ADDR_W{(state_q == ST_WAIT) && (idx_q == IDX_W'(i))}}
                                  & yIn[i*ADDR_W +: ADDR_W]);
         memWeight = memWeight | ({WEIGHT_W{(state_q == ST_WAIT) && (idx_q == IDX_W'(i))}}
                                  & weightIn[i*WEIGHT_W +: WEIGHT_W]);
         memRead   = memRead   | ((state_q == ST_WAIT) && (idx_q == IDX_W'(i)) && enaReadIn[i]);
         memWrite  = memWrite  | ((state_q == ST_WAIT) && (idx_q == IDX_W'(i)) && enaWriteIn[i]);
      end
   end

   assign enaScanOut = ena_q;
   assign busy       = busy_q;
   assign allDone    = all_done_q;
   assign activeIdx  = idx_q;
   assign timeoutErr = terr_q;

endmodule
